i2s_rx: RTL and testbench

- I2S receiver (slave) that deserialises an externally clocked I2S stream (sclk, lrclk, sdata) into parallel signed left/right samples in the system clock domain.
- It is the counterpart of the i2s transmitter in the video/audio path. It serves as the audio-input path for external codec/ADC sources (tape/line-in sampling, loopback test of the i2s output), feeding mixers that consume the same 16-bit signed format.
- All I2S inputs are asynchronous and are oversampled by clk.

---
 rtl/i2s_rx_if.sv | 28 ++
 rtl/i2s_rx.sv | 177 +++++++++++++++++
 tb/tb_i2s_rx.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
// I2S receiver bus bundle.
// Groups the asynchronous serial lines (sclk, lrclk, sdata) with the
// parallel sample outputs (left_chan, right_chan, sample_strobe, frame_err,
// locked) of the receiver.
//   slave  : receiver side (takes the serial lines, drives the samples)
//   master : source/consumer side (drives the serial lines, takes the samples)
interface i2s_rx_if #(
  parameter int WIDTH = 16
);
  logic                    sclk;
  logic                    lrclk;
  logic                    sdata;
  logic signed [WIDTH-1:0] left_chan;
  logic signed [WIDTH-1:0] right_chan;
  logic                    sample_strobe;
  logic                    frame_err;
  logic                    locked;

  modport slave (
    input  sclk, lrclk, sdata,
    output left_chan, right_chan, sample_strobe, frame_err, locked
  );

  modport master (
    output sclk, lrclk, sdata,
    input  left_chan, right_chan, sample_strobe, frame_err, locked
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples an externally clocked I2S stream with clk
// and delivers signed left/right sample pairs in the clk domain.
// Ports:
//   clk      system clock, all logic on its rising edge
//   reset_n  asynchronous active-low reset
//   bus      i2s_rx_if.slave
//              sclk/lrclk/sdata   asynchronous I2S inputs
//              left_chan/right_chan last complete pair (signed, WIDTH bits)
//              sample_strobe      one-clk pulse when the pair updates
//              frame_err          one-clk pulse when a committed word was short
//              locked             high while a valid stereo stream is received
module i2s_rx #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input logic     clk,
  input logic     reset_n,
  i2s_rx_if.slave bus
);
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]              r_sclk_sync;
  logic [1:0]              r_lrclk_sync;
  logic [1:0]              r_sdata_sync;
  logic                    r_sclk_d;
  logic                    r_ws_q;
  logic                    r_ws_qq;
  logic [WIDTH-1:0]        r_shreg;
  logic [CNT_W-1:0]        r_bitcnt;
  logic signed [WIDTH-1:0] r_left_hold;
  logic signed [WIDTH-1:0] r_left;
  logic signed [WIDTH-1:0] r_right;
  logic                    r_have_left;
  logic                    r_strobe;
  logic                    r_ferr;
  logic [IDLE_W-1:0]       r_idle;

  logic             w_sclk;
  logic             w_ws;
  logic             w_bit;
  logic             w_bit_edge;
  logic             w_boundary;
  logic             w_commit;
  logic             w_timeout;
  logic             w_word_full;
  logic [WIDTH-1:0] w_ins;

  assign w_sclk      = r_sclk_sync[1];
  assign w_ws        = r_lrclk_sync[1];
  assign w_bit       = r_sdata_sync[1];
  assign w_bit_edge  = w_sclk & ~r_sclk_d;
  // ws_q/ws_qq still hold the values from the two previous bit edges, so a
  // difference here means the current bit is the MSB of a new word.
  assign w_boundary  = w_bit_edge & (r_ws_q != r_ws_qq);
  assign w_commit    = w_boundary & (r_state != ST_HUNT);
  assign w_timeout   = ~w_bit_edge & (r_idle == IDLE_W'(TIMEOUT - 1));
  assign w_word_full = (r_bitcnt >= CNT_W'(WIDTH));
  // Bits land at their final left-justified position, so a short word is
  // already zero-filled in its LSBs when it is committed.
  assign w_ins       = {w_bit, {(WIDTH-1){1'b0}}} >> r_bitcnt;

  // Input synchronisers and sclk edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_sync  <= '0;
      r_lrclk_sync <= '0;
      r_sdata_sync <= '0;
      r_sclk_d     <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[0], bus.sclk};
      r_lrclk_sync <= {r_lrclk_sync[0], bus.lrclk};
      r_sdata_sync <= {r_sdata_sync[0], bus.sdata};
      r_sclk_d     <= w_sclk;
    end
  end

  // Bit capture: word-select history, shift register, bit counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ws_q   <= 1'b0;
      r_ws_qq  <= 1'b0;
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else if (w_bit_edge) begin
      r_ws_q  <= w_ws;
      r_ws_qq <= r_ws_q;
      if (w_boundary) begin
        r_shreg  <= {w_bit, {(WIDTH-1){1'b0}}};
        r_bitcnt <= CNT_W'(1);
      end else if (!w_word_full) begin
        r_shreg  <= r_shreg | w_ins;
        r_bitcnt <= r_bitcnt + CNT_W'(1);
      end
    end
  end

  // Commit of the word that just ended (channel = ws_qq) and pairing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_left_hold <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_have_left <= 1'b0;
      r_strobe    <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_ferr   <= 1'b0;
      if (w_commit) begin
        r_ferr <= ~w_word_full;
        if (!r_ws_qq) begin
          r_left_hold <= r_shreg;
          r_have_left <= 1'b1;
        end else if (r_have_left) begin
          r_left      <= r_left_hold;
          r_right     <= r_shreg;
          r_strobe    <= 1'b1;
          r_have_left <= 1'b0;
        end
      end
      if (w_timeout) begin
        r_have_left <= 1'b0;
      end
    end
  end

  // Idle counter: clk cycles since the last bit edge, saturating at TIMEOUT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle <= '0;
    end else if (w_bit_edge) begin
      r_idle <= '0;
    end else if (r_idle != IDLE_W'(TIMEOUT)) begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end

  // Receive state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving SYNC on the registered strobe makes locked rise the cycle after
  // the first strobe rather than alongside it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HUNT:   if (w_boundary) w_state_nxt = ST_SYNC;
      ST_SYNC:   if (r_strobe)   w_state_nxt = ST_LOCKED;
      ST_LOCKED: w_state_nxt = ST_LOCKED;
      default:   w_state_nxt = ST_HUNT;
    endcase
    if (w_timeout) begin
      w_state_nxt = ST_HUNT;
    end
  end

  assign bus.left_chan     = r_left;
  assign bus.right_chan    = r_right;
  assign bus.sample_strobe = r_strobe;
  assign bus.frame_err     = r_ferr;
  assign bus.locked        = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_i2s_rx.sv
// Testbench for i2s_rx: I2S frames are generated at sclk = clk/8, every
// expected sample pair is queued when its frame is driven and compared when
// the DUT strobes it out.
module tb_i2s_rx;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int NFR     = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  i2s_rx_if #(.WIDTH(WIDTH)) bus ();

  i2s_rx #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  typedef struct {
    int          slot;
    int          nbits;
    logic [31:0] l;
    logic [31:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    int          ferr_frame;
  } vec_t;

  pair_t exp_q[$];
  int    checks   = 0;
  int    errors   = 0;
  int    n_strobe = 0;
  int    n_ferr   = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // One clk cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    pair_t e;
    @(posedge clk);
    #1;
    if (reset_n) begin
      if (bus.sample_strobe) begin
        n_strobe++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected got L=%h R=%h required no strobe",
                   bus.left_chan, bus.right_chan);
        end else begin
          e = exp_q.pop_front();
          if (bus.left_chan !== e.l || bus.right_chan !== e.r) begin
            errors++;
            $display("FAIL strobe_pair got L=%h R=%h required L=%h R=%h",
                     bus.left_chan, bus.right_chan, e.l, e.r);
          end
        end
      end
      if (bus.frame_err && bus.locked) n_ferr++;
    end
  endtask

  task automatic send_bit(input logic ws, input logic d);
    bus.sclk  = 1'b0;
    bus.lrclk = ws;
    bus.sdata = d;
    repeat (4) tick();
    bus.sclk = 1'b1;
    repeat (4) tick();
  endtask

  // Slot positions [from..to] of one word; ws switches to ws_nxt on the last
  // slot bit so the next word's MSB follows one sclk after the ws change.
  task automatic send_word(input logic [31:0] w, input int nbits, input int slot,
                           input logic ws_cur, input logic ws_nxt,
                           input int from, input int to);
    logic d;
    for (int i = from; i <= to; i++) begin
      d = (i < nbits) ? w[nbits-1-i] : 1'b0;
      send_bit((i == slot - 1) ? ws_nxt : ws_cur, d);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int nbits, input int slot);
    send_word(l, nbits, slot, 1'b0, 1'b1, 0, slot - 1);
    send_word(r, nbits, slot, 1'b1, 1'b0, 0, slot - 1);
  endtask

  // MSB of a following left word: closes the last right word.
  task automatic lead_bit();
    send_bit(1'b0, 1'b1);
    repeat (4) tick();
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    exp_q.push_back(p);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    bus.sclk  = 1'b0;
    bus.lrclk = 1'b0;
    bus.sdata = 1'b0;
    exp_q.delete();
    n_strobe = 0;
    n_ferr   = 0;
    repeat (3) tick();
    check("rst_left", bus.left_chan, 16'h0000);
    check("rst_right", bus.right_chan, 16'h0000);
    check("rst_strobe", 16'(bus.sample_strobe), 16'h0);
    check("rst_ferr", 16'(bus.frame_err), 16'h0);
    check("rst_locked", 16'(bus.locked), 16'h0);
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  vec_t        vecs[5];
  logic [15:0] rl[3];
  logic [15:0] rr[3];

  initial begin
    bus.sclk  = 1'b0;
    bus.lrclk = 1'b0;
    bus.sdata = 1'b0;

    vecs[0] = '{16, 16, 32'h0000_1234, 32'h0000_ABCD, 16'h1234, 16'hABCD, 0};
    vecs[1] = '{32, 32, 32'h8001_FFFF, 32'h7FFF_0000, 16'h8001, 16'h7FFF, 0};
    vecs[2] = '{12, 12, 32'h0000_0ABC, 32'h0000_0123, 16'hABC0, 16'h1230, 2};
    vecs[3] = '{24, 24, 32'h00FF_FF80, 32'h0000_0100, 16'hFFFF, 16'h0001, 0};
    vecs[4] = '{16, 16, 32'h0000_8000, 32'h0000_7FFF, 16'h8000, 16'h7FFF, 0};

    // Table: NFR identical frames from a fresh reset; frame 1 only brings
    // the receiver out of HUNT, frames 2..NFR each produce one strobe.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      send_frame(vecs[v].l, vecs[v].r, vecs[v].nbits, vecs[v].slot);
      check("unlocked_after_frame1", 16'(bus.locked), 16'h0);
      check("left_idle_after_frame1", bus.left_chan, 16'h0000);
      for (int f = 1; f < NFR; f++) begin
        push(vecs[v].exp_l, vecs[v].exp_r);
        send_frame(vecs[v].l, vecs[v].r, vecs[v].nbits, vecs[v].slot);
      end
      lead_bit();
      check_int("vec_pending", exp_q.size(), 0);
      check_int("vec_strobes", n_strobe, NFR - 1);
      check("vec_left", bus.left_chan, vecs[v].exp_l);
      check("vec_right", bus.right_chan, vecs[v].exp_r);
      check("vec_locked", 16'(bus.locked), 16'h1);
      check_int("vec_ferr", n_ferr, vecs[v].ferr_frame * (NFR - 2));
    end

    // Timeout: sclk stops, lock drops, outputs hold; then a new stream.
    repeat (TIMEOUT + 10) tick();
    check("to_locked", 16'(bus.locked), 16'h0);
    check("to_left_hold", bus.left_chan, 16'h8000);
    check("to_right_hold", bus.right_chan, 16'h7FFF);
    n_strobe = 0;
    send_frame(32'h5555, 32'h0AAA, 16, 16);
    check_int("to_no_strobe_partial", n_strobe, 0);
    check("to_unlocked_partial", 16'(bus.locked), 16'h0);
    for (int f = 0; f < 2; f++) begin
      push(16'h5555, 16'h0AAA);
      send_frame(32'h5555, 32'h0AAA, 16, 16);
    end
    lead_bit();
    check_int("to_pending", exp_q.size(), 0);
    check_int("to_strobes", n_strobe, 2);
    check("to_left", bus.left_chan, 16'h5555);
    check("to_right", bus.right_chan, 16'h0AAA);
    check("to_relocked", 16'(bus.locked), 16'h1);

    // Reset midway through a right word.
    do_reset();
    send_frame(32'h3C5A, 32'hC3A5, 16, 16);
    for (int f = 0; f < 2; f++) begin
      push(16'h3C5A, 16'hC3A5);
      send_frame(32'h3C5A, 32'hC3A5, 16, 16);
    end
    send_word(32'h3C5A, 16, 16, 1'b0, 1'b1, 0, 15);
    send_word(32'hC3A5, 16, 16, 1'b1, 1'b0, 0, 7);
    check_int("mr_pending", exp_q.size(), 0);
    check("mr_pre_left", bus.left_chan, 16'h3C5A);
    reset_n = 1'b0;
    #1;
    check("mr_left", bus.left_chan, 16'h0000);
    check("mr_right", bus.right_chan, 16'h0000);
    check("mr_strobe", 16'(bus.sample_strobe), 16'h0);
    check("mr_ferr", 16'(bus.frame_err), 16'h0);
    check("mr_locked", 16'(bus.locked), 16'h0);
    repeat (3) tick();
    reset_n  = 1'b1;
    n_strobe = 0;
    send_word(32'hC3A5, 16, 16, 1'b1, 1'b0, 8, 15);
    send_word(32'h1357, 16, 16, 1'b0, 1'b1, 0, 15);
    check_int("mr_no_strobe_partial", n_strobe, 0);
    send_word(32'hFDB9, 16, 16, 1'b1, 1'b0, 0, 15);
    for (int f = 0; f < 2; f++) begin
      push(16'h1357, 16'hFDB9);
      send_frame(32'h1357, 32'hFDB9, 16, 16);
    end
    push(16'h1357, 16'hFDB9);
    lead_bit();
    check_int("mr_pending", exp_q.size(), 0);
    check_int("mr_strobes", n_strobe, 3);
    check("mr_left_after", bus.left_chan, 16'h1357);
    check("mr_right_after", bus.right_chan, 16'hFDB9);

    // Stream starting with a right word: that word is discarded and the
    // first strobe carries the following pair.
    do_reset();
    for (int f = 0; f < 3; f++) begin
      rl[f] = 16'($urandom_range(0, 65535));
      rr[f] = 16'($urandom_range(0, 65535));
    end
    send_word(32'h0F0F, 16, 16, 1'b1, 1'b0, 0, 15);
    check_int("rs_no_strobe_right", n_strobe, 0);
    for (int f = 0; f < 3; f++) begin
      push(rl[f], rr[f]);
      send_frame({16'h0, rl[f]}, {16'h0, rr[f]}, 16, 16);
    end
    lead_bit();
    check_int("rs_pending", exp_q.size(), 0);
    check_int("rs_strobes", n_strobe, 3);
    check("rs_left", bus.left_chan, rl[2]);
    check("rs_right", bus.right_chan, rr[2]);
    check("rs_locked", 16'(bus.locked), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
